// File: rtl/mips_iter_divider_if.sv
// Operand/result stream bundle between the execute stage (master) and a divider (slave).
interface mips_iter_divider_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0]   s_axis_dividend_tdata;
  logic                s_axis_dividend_tvalid;
  logic                s_axis_dividend_tready;
  logic [DATA_W-1:0]   s_axis_divisor_tdata;
  logic                s_axis_divisor_tvalid;
  logic                s_axis_divisor_tready;
  logic [2*DATA_W-1:0] m_axis_dout_tdata;
  logic                m_axis_dout_tvalid;
  logic                busy;

  modport master (
    output s_axis_dividend_tdata, s_axis_dividend_tvalid,
    input  s_axis_dividend_tready,
    output s_axis_divisor_tdata, s_axis_divisor_tvalid,
    input  s_axis_divisor_tready,
    input  m_axis_dout_tdata, m_axis_dout_tvalid, busy
  );

  modport slave (
    input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
    output s_axis_dividend_tready,
    input  s_axis_divisor_tdata, s_axis_divisor_tvalid,
    output s_axis_divisor_tready,
    output m_axis_dout_tdata, m_axis_dout_tvalid, busy
  );
endinterface

// File: rtl/mips_iter_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle; result pulse DATA_W+1 cycles after
// the last operand is taken. Operand channels stall via tready while held; result has no backpressure.
module mips_iter_divider #(
  parameter int SIGNED = 1,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  mips_iter_divider_if.slave dif
);
  localparam int               CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);
  localparam logic             IS_SIGNED = (SIGNED != 0);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic                dvd_held_q, dvd_held_d;
  logic                dsr_held_q, dsr_held_d;
  logic [DATA_W-1:0]   dvd_hold_q, dvd_hold_d;
  logic [DATA_W-1:0]   dsr_hold_q, dsr_hold_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dsr_q, dsr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] dout_q, dout_d;
  logic                dout_vld_q, dout_vld_d;

  logic                dvd_fire, dsr_fire;
  logic [DATA_W:0]     shift;
  logic [DATA_W+1:0]   trial;
  logic                qbit;
  logic [DATA_W-1:0]   rem_nxt, quo_nxt;
  logic                unused_trial;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
    if (IS_SIGNED && v[DATA_W-1]) return ~v + ONE;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] negate_if(input logic n, input logic [DATA_W-1:0] v);
    return n ? (~v + ONE) : v;
  endfunction

  assign dif.s_axis_dividend_tready = ~dvd_held_q & ~reset;
  assign dif.s_axis_divisor_tready  = ~dsr_held_q & ~reset;
  assign dvd_fire = dif.s_axis_dividend_tvalid & dif.s_axis_dividend_tready;
  assign dsr_fire = dif.s_axis_divisor_tvalid & dif.s_axis_divisor_tready;

  // The partial remainder keeps its full width so divisors with the MSB set stay exact.
  assign shift        = {rem_q, quo_q[DATA_W-1]};
  assign trial        = {1'b0, shift} - {2'b00, dsr_q};
  assign qbit         = ~trial[DATA_W+1];
  assign rem_nxt      = qbit ? trial[DATA_W-1:0] : shift[DATA_W-1:0];
  assign quo_nxt      = {quo_q[DATA_W-2:0], qbit};
  assign unused_trial = trial[DATA_W];

  always_comb begin
    state_d    = state_q;
    dvd_held_d = dvd_held_q;
    dsr_held_d = dsr_held_q;
    dvd_hold_d = dvd_hold_q;
    dsr_hold_d = dsr_hold_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dsr_d      = dsr_q;
    cnt_d      = cnt_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;

    if (dvd_fire) begin
      dvd_hold_d = dif.s_axis_dividend_tdata;
      dvd_held_d = 1'b1;
    end
    if (dsr_fire) begin
      dsr_hold_d = dif.s_axis_divisor_tdata;
      dsr_held_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (dvd_held_q && dsr_held_q) begin
          state_d    = CALC;
          dvd_held_d = 1'b0;
          dsr_held_d = 1'b0;
          quo_d      = magnitude(dvd_hold_q);
          dsr_d      = magnitude(dsr_hold_q);
          rem_d      = '0;
          cnt_d      = '0;
          neg_quo_d  = IS_SIGNED & (dvd_hold_q[DATA_W-1] ^ dsr_hold_q[DATA_W-1]);
          neg_rem_d  = IS_SIGNED & dvd_hold_q[DATA_W-1];
        end
      end
      CALC: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d    = DONE;
          dout_vld_d = 1'b1;
          dout_d     = {negate_if(neg_quo_q, quo_nxt), negate_if(neg_rem_q, rem_nxt)};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dvd_held_q <= 1'b0;
      dsr_held_q <= 1'b0;
      dvd_hold_q <= '0;
      dsr_hold_q <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dsr_q      <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_held_q <= dvd_held_d;
      dsr_held_q <= dsr_held_d;
      dvd_hold_q <= dvd_hold_d;
      dsr_hold_q <= dsr_hold_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dsr_q      <= dsr_d;
      cnt_q      <= cnt_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign dif.m_axis_dout_tdata  = dout_q;
  assign dif.m_axis_dout_tvalid = dout_vld_q;
  assign dif.busy               = (state_q != IDLE);

endmodule

// File: tb/tb_mips_iter_divider.sv
// Bench for the signed (DIV) and unsigned (DIVU) divider instances with a result scoreboard.
module tb_mips_iter_divider;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_iter_divider_if #(.DATA_W(32)) ifs ();
  mips_iter_divider_if #(.DATA_W(32)) ifu ();

  mips_iter_divider #(.SIGNED(1), .DATA_W(32)) u_div  (.clk(clk), .reset(reset), .dif(ifs.slave));
  mips_iter_divider #(.SIGNED(0), .DATA_W(32)) u_divu (.clk(clk), .reset(reset), .dif(ifu.slave));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] exp_s[$];
  logic [63:0] exp_u[$];
  logic [63:0] got_s[$];
  logic [63:0] got_u[$];
  int          vcyc_s[$];
  int          vcyc_u[$];
  int          pulses_s = 0;
  int          pulses_u = 0;
  int          rd_s = 0;
  int          rd_u = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ifs.m_axis_dout_tvalid === 1'b1) begin
      got_s.push_back(ifs.m_axis_dout_tdata);
      vcyc_s.push_back(cyc);
      pulses_s++;
    end
    if (ifu.m_axis_dout_tvalid === 1'b1) begin
      got_u.push_back(ifu.m_axis_dout_tdata);
      vcyc_u.push_back(cyc);
      pulses_u++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    ifs.s_axis_dividend_tvalid = 1'b0;
    ifs.s_axis_divisor_tvalid  = 1'b0;
    ifu.s_axis_dividend_tvalid = 1'b0;
    ifu.s_axis_divisor_tvalid  = 1'b0;
  endtask

  // Offers both operands in the same cycle; returns one cycle after the handshake edge.
  task automatic drive_pair(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    if (sgn) begin
      ifs.s_axis_dividend_tdata  = a;
      ifs.s_axis_divisor_tdata   = b;
      ifs.s_axis_dividend_tvalid = 1'b1;
      ifs.s_axis_divisor_tvalid  = 1'b1;
    end else begin
      ifu.s_axis_dividend_tdata  = a;
      ifu.s_axis_divisor_tdata   = b;
      ifu.s_axis_dividend_tvalid = 1'b1;
      ifu.s_axis_divisor_tvalid  = 1'b1;
    end
    tick;
    clear_inputs;
  endtask

  task automatic wait_result(input bit sgn, input int budget, output bit ok,
                             output logic [63:0] dat, output int vc);
    int n;
    n   = 0;
    ok  = 1'b0;
    dat = '0;
    vc  = -1;
    while (!ok && n < budget) begin
      if (sgn ? (got_s.size() > rd_s) : (got_u.size() > rd_u)) ok = 1'b1;
      else begin
        tick;
        n++;
      end
    end
    if (ok) begin
      if (sgn) begin
        dat = got_s[rd_s];
        vc  = vcyc_s[rd_s];
        rd_s++;
      end else begin
        dat = got_u[rd_u];
        vc  = vcyc_u[rd_u];
        rd_u++;
      end
    end
  endtask

  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    ma = (sgn && a[31]) ? (~a + 32'd1) : a;
    mb = (sgn && b[31]) ? (~b + 32'd1) : b;
    if (mb == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (sgn && (a[31] ^ b[31])) q = ~q + 32'd1;
    if (sgn && a[31])           r = ~r + 32'd1;
    return {q, r};
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    checks++;
    if (ifs.s_axis_dividend_tready !== 1'b0 || ifu.s_axis_divisor_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_tready got=%b/%b expected=0/0", ifs.s_axis_dividend_tready, ifu.s_axis_divisor_tready);
    end
    checks++;
    if (ifs.busy !== 1'b0 || ifu.busy !== 1'b0 || ifs.m_axis_dout_tvalid !== 1'b0 || ifu.m_axis_dout_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_vld got busy=%b/%b vld=%b/%b expected all 0",
               ifs.busy, ifu.busy, ifs.m_axis_dout_tvalid, ifu.m_axis_dout_tvalid);
    end
    checks++;
    if (ifs.m_axis_dout_tdata !== 64'd0 || ifu.m_axis_dout_tdata !== 64'd0) begin
      errors++;
      $display("FAIL reset_tdata got=%h/%h expected=0", ifs.m_axis_dout_tdata, ifu.m_axis_dout_tdata);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ifs.s_axis_dividend_tready !== 1'b1 || ifs.s_axis_divisor_tready !== 1'b1 ||
        ifu.s_axis_dividend_tready !== 1'b1 || ifu.s_axis_divisor_tready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_tready got=%b%b%b%b expected=1111", ifs.s_axis_dividend_tready,
               ifs.s_axis_divisor_tready, ifu.s_axis_dividend_tready, ifu.s_axis_divisor_tready);
    end
    tick;
  endtask

  task automatic test_same_cycle;
    int e, n, p0, vc;
    bit ok;
    logic [63:0] dat;
    p0 = pulses_u;
    exp_u.push_back(64'h0000000E_00000002);
    drive_pair(1'b0, 32'd100, 32'd7);
    e = cyc;
    checks++;
    if (ifu.s_axis_dividend_tready !== 1'b0 || ifu.s_axis_divisor_tready !== 1'b0 || ifu.busy !== 1'b0) begin
      errors++;
      $display("FAIL held_tready got rdy=%b%b busy=%b expected rdy=00 busy=0",
               ifu.s_axis_dividend_tready, ifu.s_axis_divisor_tready, ifu.busy);
    end
    tick;
    checks++;
    if (ifu.s_axis_dividend_tready !== 1'b1 || ifu.busy !== 1'b1) begin
      errors++;
      $display("FAIL calc_entry got rdy=%b busy=%b expected rdy=1 busy=1", ifu.s_axis_dividend_tready, ifu.busy);
    end
    n = 0;
    while (ifu.busy === 1'b1 && n < 60) begin
      tick;
      n++;
    end
    checks++;
    if (cyc - e != 34) begin
      errors++;
      $display("FAIL busy_span got=%0d expected=34", cyc - e);
    end
    wait_result(1'b0, 10, ok, dat, vc);
    checks++;
    if (!ok || dat !== exp_u.pop_front()) begin
      errors++;
      $display("FAIL udiv_100_7 got=%h ok=%0d expected=0000000e00000002", dat, ok);
    end
    checks++;
    if (vc - e != 33) begin
      errors++;
      $display("FAIL udiv_latency got=%0d expected=33", vc - e);
    end
    tick;
    tick;
    checks++;
    if (pulses_u - p0 != 1) begin
      errors++;
      $display("FAIL udiv_single_pulse got=%0d expected=1", pulses_u - p0);
    end
  endtask

  task automatic test_signed;
    logic [31:0] a[3] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'h0000_0007};
    logic [31:0] b[3] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [63:0] r[3] = '{64'hFFFFFFFD_FFFFFFFF, 64'h80000000_00000000, 64'hFFFFFFFD_00000001};
    bit ok;
    logic [63:0] dat, ex;
    int vc;
    for (int i = 0; i < 3; i++) begin
      exp_s.push_back(r[i]);
      drive_pair(1'b1, a[i], b[i]);
      wait_result(1'b1, 60, ok, dat, vc);
      ex = exp_s.pop_front();
      checks++;
      if (!ok || dat !== ex) begin
        errors++;
        $display("FAIL sdiv_case%0d got=%h ok=%0d expected=%h", i, dat, ok, ex);
      end
      tick;
    end
  endtask

  task automatic test_div_zero;
    bit ok;
    logic [63:0] dat, ex;
    int vc;
    exp_u.push_back(64'hFFFFFFFF_00000005);
    drive_pair(1'b0, 32'd5, 32'd0);
    wait_result(1'b0, 60, ok, dat, vc);
    ex = exp_u.pop_front();
    checks++;
    if (!ok || dat !== ex) begin
      errors++;
      $display("FAIL udiv_by_zero got=%h ok=%0d expected=%h", dat, ok, ex);
    end
    tick;
    exp_s.push_back(64'h00000001_FFFFFFFB);
    drive_pair(1'b1, 32'hFFFF_FFFB, 32'd0);
    wait_result(1'b1, 60, ok, dat, vc);
    ex = exp_s.pop_front();
    checks++;
    if (!ok || dat !== ex) begin
      errors++;
      $display("FAIL sdiv_by_zero got=%h ok=%0d expected=%h", dat, ok, ex);
    end
    tick;
  endtask

  task automatic test_staggered;
    int e, vc, bad;
    bit ok;
    logic [63:0] dat, ex;
    bad = 0;
    exp_u.push_back(64'h0000001E_0000000A);
    ifu.s_axis_dividend_tdata  = 32'd1000;
    ifu.s_axis_dividend_tvalid = 1'b1;
    tick;
    for (int i = 1; i <= 10; i++) begin
      ifu.s_axis_dividend_tdata  = 32'd9999;
      ifu.s_axis_dividend_tvalid = 1'b1;
      if (ifu.s_axis_dividend_tready !== 1'b0) bad++;
      if (i == 10) begin
        ifu.s_axis_divisor_tdata  = 32'd33;
        ifu.s_axis_divisor_tvalid = 1'b1;
      end
      tick;
    end
    clear_inputs;
    e = cyc;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stagger_tready_low got=%0d cycles with tready=1 expected=0", bad);
    end
    wait_result(1'b0, 60, ok, dat, vc);
    ex = exp_u.pop_front();
    checks++;
    if (!ok || dat !== ex) begin
      errors++;
      $display("FAIL stagger_result got=%h ok=%0d expected=%h", dat, ok, ex);
    end
    checks++;
    if (vc - e != 33) begin
      errors++;
      $display("FAIL stagger_latency got=%0d expected=33", vc - e);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int e, vc1, vc2;
    bit ok1, ok2;
    logic [63:0] d1, d2, ex1, ex2;
    exp_s.push_back(64'hFFFFFFF5_00000001);
    drive_pair(1'b1, 32'd100, 32'hFFFF_FFF7);
    e = cyc;
    for (int i = 0; i < 5; i++) tick;
    checks++;
    if (ifs.s_axis_dividend_tready !== 1'b1 || ifs.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept_in_calc got rdy=%b busy=%b expected 1/1", ifs.s_axis_dividend_tready, ifs.busy);
    end
    exp_s.push_back(64'hFFFFFF72_FFFFFFFA);
    drive_pair(1'b1, 32'hFFFF_FC18, 32'd7);
    wait_result(1'b1, 60, ok1, d1, vc1);
    wait_result(1'b1, 60, ok2, d2, vc2);
    ex1 = exp_s.pop_front();
    ex2 = exp_s.pop_front();
    checks++;
    if (!ok1 || d1 !== ex1) begin
      errors++;
      $display("FAIL b2b_first got=%h ok=%0d expected=%h", d1, ok1, ex1);
    end
    checks++;
    if (!ok2 || d2 !== ex2) begin
      errors++;
      $display("FAIL b2b_second got=%h ok=%0d expected=%h", d2, ok2, ex2);
    end
    checks++;
    if (vc1 - e != 33 || vc2 - vc1 != 34) begin
      errors++;
      $display("FAIL b2b_spacing got=%0d/%0d expected=33/34", vc1 - e, vc2 - vc1);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    int p0, vc;
    bit ok;
    logic [63:0] dat, ex;
    p0 = pulses_u;
    drive_pair(1'b0, 32'd50, 32'd5);
    for (int i = 0; i < 11; i++) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    checks++;
    if (ifu.busy !== 1'b0 || ifu.s_axis_dividend_tready !== 1'b1 || ifu.s_axis_divisor_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_state got busy=%b rdy=%b%b expected busy=0 rdy=11",
               ifu.busy, ifu.s_axis_dividend_tready, ifu.s_axis_divisor_tready);
    end
    for (int i = 0; i < 40; i++) tick;
    checks++;
    if (pulses_u != p0) begin
      errors++;
      $display("FAIL reset_mid_no_pulse got=%0d pulses expected=0", pulses_u - p0);
    end
    exp_u.push_back(64'h00000003_00000000);
    drive_pair(1'b0, 32'd9, 32'd3);
    wait_result(1'b0, 60, ok, dat, vc);
    ex = exp_u.pop_front();
    checks++;
    if (!ok || dat !== ex) begin
      errors++;
      $display("FAIL reset_mid_fresh got=%h ok=%0d expected=%h", dat, ok, ex);
    end
    tick;
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic [63:0] dat, ex;
    bit ok;
    int vc;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) b = b >> $urandom_range(30, 1);
      if (i % 4 == 1) b = b | 32'h8000_0000;
      if (i == 10) a = 32'h8000_0000;
      exp_s.push_back(model(1'b1, a, b));
      exp_u.push_back(model(1'b0, a, b));
      drive_pair(1'b1, a, b);
      wait_result(1'b1, 60, ok, dat, vc);
      ex = exp_s.pop_front();
      checks++;
      if (!ok || dat !== ex) begin
        errors++;
        $display("FAIL rand_sdiv a=%h b=%h got=%h expected=%h", a, b, dat, ex);
      end
      tick;
      drive_pair(1'b0, a, b);
      wait_result(1'b0, 60, ok, dat, vc);
      ex = exp_u.pop_front();
      checks++;
      if (!ok || dat !== ex) begin
        errors++;
        $display("FAIL rand_udiv a=%h b=%h got=%h expected=%h", a, b, dat, ex);
      end
      tick;
    end
  endtask

  initial begin
    ifs.s_axis_dividend_tdata = '0;
    ifs.s_axis_divisor_tdata  = '0;
    ifu.s_axis_dividend_tdata = '0;
    ifu.s_axis_divisor_tdata  = '0;
    clear_inputs;
    test_reset;
    test_same_cycle;
    test_signed;
    test_div_zero;
    test_staggered;
    test_back_to_back;
    test_reset_mid;
    test_random;
    for (int i = 0; i < 4; i++) tick;
    checks++;
    if (got_s.size() != rd_s || got_u.size() != rd_u || exp_s.size() != 0 || exp_u.size() != 0) begin
      errors++;
      $display("FAIL leftover got extra=%0d/%0d pending=%0d/%0d expected all 0",
               got_s.size() - rd_s, got_u.size() - rd_u, exp_s.size(), exp_u.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
